// File: rtl/aoc_lsu_pkg.sv
// Shared widths, no-solution sentinel, dispatcher state encoding and held-line layout
// for the line_solving_unit array and its dispatcher.
package aoc_lsu_pkg;

    localparam int MC  = 10;
    localparam int MBC = 13;
    localparam int BPJ = 9;
    localparam int AW  = 16;
    localparam int BCW = $clog2(MBC + 1);

    // An LSU reports this value when no button combination reaches the targets.
    localparam logic [AW-1:0] NO_SOLUTION = {AW{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        START = 2'd2
    } dispatch_state_t;

    typedef struct packed {
        logic [BCW-1:0]      button_count;
        logic [MC*MBC-1:0]   buttons;
        logic [MC*BPJ-1:0]   machines;
    } line_t;

endpackage

// File: rtl/lsu_result_summer.sv
// Masked sum, pulse count and no-solution detect across all LSU result ports.
// Latency: purely combinational. Backpressure: none, every pulse is consumed the cycle it arrives.
module lsu_result_summer
    import aoc_lsu_pkg::*;
#(
    parameter int LSU_COUNT = 4,
    parameter int SUM_WIDTH = 32,
    parameter int CNT_WIDTH = 3
) (
    input  logic [LSU_COUNT-1:0]    result_ready,
    input  logic [LSU_COUNT*AW-1:0] results,
    output logic [SUM_WIDTH-1:0]    sum,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    hit_unsolvable
);

    always_comb begin
        sum            = '0;
        count          = '0;
        hit_unsolvable = 1'b0;
        for (int i = 0; i < LSU_COUNT; i++) begin
            if (result_ready[i]) begin
                // Unsolvable lines still count as completed, but add nothing.
                count = count + CNT_WIDTH'(1);
                if (results[i*AW +: AW] == NO_SOLUTION) begin
                    hit_unsolvable = 1'b1;
                end else begin
                    sum = sum + SUM_WIDTH'(results[i*AW +: AW]);
                end
            end
        end
    end

endmodule

// File: rtl/lsu_dispatcher.sv
// Hands parsed lines to the lowest-index idle LSU and accumulates their results (DISPATCH_STATS_EN adds stats ports).
// Latency: accept -> start pulse 2 cycles, one line per 3 cycles; results land in total 1 cycle after the pulse.
// Backpressure: in_ready drops while a line is held; stays held with no start while no LSU is available.
module lsu_dispatcher
    import aoc_lsu_pkg::*;
#(
    parameter int LSU_COUNT   = 4,
    parameter int TOTAL_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [BCW-1:0]          in_button_count,
    input  logic [MC*MBC-1:0]       in_buttons,
    input  logic [MC*BPJ-1:0]       in_machines,
    output logic [LSU_COUNT-1:0]    lsu_start,
    input  logic [LSU_COUNT-1:0]    lsu_available,
    output logic [BCW-1:0]          lsu_button_count,
    output logic [MC*MBC-1:0]       lsu_buttons,
    output logic [MC*BPJ-1:0]       lsu_machines,
    input  logic [LSU_COUNT-1:0]    lsu_result_ready,
    input  logic [LSU_COUNT*AW-1:0] lsu_results,
`ifdef DISPATCH_STATS_EN
    output logic [TOTAL_WIDTH-1:0]  lines_done,
    output logic [AW-1:0]           max_result,
`endif
    output logic [TOTAL_WIDTH-1:0]  total,
    output logic                    done,
    output logic                    unsolvable
);

    localparam int CNT_WIDTH = $clog2(LSU_COUNT + 1);

    dispatch_state_t        state;
    line_t                  held;
    logic                   last_seen;
    logic [TOTAL_WIDTH-1:0] dispatched;
    logic [TOTAL_WIDTH-1:0] completed;
    logic [LSU_COUNT-1:0]   pick;
    logic                   found;
    logic [TOTAL_WIDTH-1:0] batch_sum;
    logic [CNT_WIDTH-1:0]   batch_count;
    logic                   batch_unsolvable;

    // The hold register is the shared LSU bus; it only changes on accept.
    assign lsu_button_count = held.button_count;
    assign lsu_buttons      = held.buttons;
    assign lsu_machines     = held.machines;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < LSU_COUNT; i++) begin
            if (lsu_available[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    lsu_result_summer #(
        .LSU_COUNT (LSU_COUNT),
        .SUM_WIDTH (TOTAL_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_summer (
        .result_ready   (lsu_result_ready),
        .results        (lsu_results),
        .sum            (batch_sum),
        .count          (batch_count),
        .hit_unsolvable (batch_unsolvable)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            lsu_start  <= '0;
            held       <= '0;
            last_seen  <= 1'b0;
            dispatched <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid && in_ready) begin
                        held.button_count <= in_button_count;
                        held.buttons      <= in_buttons;
                        held.machines     <= in_machines;
                        last_seen         <= in_last;
                        in_ready          <= 1'b0;
                        state             <= HELD;
                    end else begin
                        in_ready <= !last_seen;
                    end
                end
                HELD: begin
                    if (|lsu_available) begin
                        lsu_start  <= pick;
                        dispatched <= dispatched + TOTAL_WIDTH'(1);
                        state      <= START;
                    end
                end
                START: begin
                    lsu_start <= '0;
                    in_ready  <= !last_seen;
                    state     <= EMPTY;
                end
                default: begin
                    lsu_start <= '0;
                    in_ready  <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    // Done waits for every dispatched line to report, counting unsolvable ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            total      <= '0;
            completed  <= '0;
            unsolvable <= 1'b0;
            done       <= 1'b0;
        end else begin
            total     <= total + batch_sum;
            completed <= completed + TOTAL_WIDTH'(batch_count);
            if (batch_unsolvable) begin
                unsolvable <= 1'b1;
            end
            if (last_seen && state == EMPTY && completed == dispatched) begin
                done <= 1'b1;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [AW-1:0] batch_max;

    assign lines_done = completed;

    always_comb begin
        batch_max = max_result;
        for (int i = 0; i < LSU_COUNT; i++) begin
            if (lsu_result_ready[i] && lsu_results[i*AW +: AW] != NO_SOLUTION
                && lsu_results[i*AW +: AW] > batch_max) begin
                batch_max = lsu_results[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            max_result <= '0;
        end else begin
            max_result <= batch_max;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dispatcher.sv
// Scoreboard bench for lsu_dispatcher: expected starts and totals are queued when driven and
// popped by negedge monitors when the DUT responds; a second instance checks 8-bit wrap.
module tb_lsu_dispatcher;
    import aoc_lsu_pkg::*;

    typedef struct packed {
        logic [3:0] start;
        line_t      ln;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_last = 1'b0;
    logic [BCW-1:0]        in_button_count = '0;
    logic [MC*MBC-1:0]     in_buttons = '0;
    logic [MC*BPJ-1:0]     in_machines = '0;
    logic [3:0]            lsu_available = '0;
    logic [3:0]            lsu_result_ready = '0;
    logic [4*AW-1:0]       lsu_results = '0;

    logic                  in_ready, in_ready8;
    logic [3:0]            lsu_start, lsu_start8;
    logic [BCW-1:0]        lsu_button_count, lsu_button_count8;
    logic [MC*MBC-1:0]     lsu_buttons, lsu_buttons8;
    logic [MC*BPJ-1:0]     lsu_machines, lsu_machines8;
    logic [31:0]           total;
    logic [7:0]            total8;
    logic                  done, done8, unsolvable, unsolvable8;
`ifdef DISPATCH_STATS_EN
    logic [31:0]           lines_done;
    logic [7:0]            lines_done8;
    logic [AW-1:0]         max_result, max_result8;
`endif

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   start_cnt = 0;
    exp_t exp_q[$];
    logic [32:0] exp_total_q[$];
    logic [31:0] model_total = '0;
    logic        model_unsolv = 1'b0;
    line_t       last_line;
    exp_t        mon_e;
    logic [32:0] mon_t;

    always #5 clk = ~clk;

    lsu_dispatcher #(.LSU_COUNT(4), .TOTAL_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_button_count(in_button_count), .in_buttons(in_buttons), .in_machines(in_machines),
        .lsu_start(lsu_start), .lsu_available(lsu_available), .lsu_button_count(lsu_button_count),
        .lsu_buttons(lsu_buttons), .lsu_machines(lsu_machines), .lsu_result_ready(lsu_result_ready),
        .lsu_results(lsu_results),
`ifdef DISPATCH_STATS_EN
        .lines_done(lines_done), .max_result(max_result),
`endif
        .total(total), .done(done), .unsolvable(unsolvable)
    );

    lsu_dispatcher #(.LSU_COUNT(4), .TOTAL_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last),
        .in_button_count(in_button_count), .in_buttons(in_buttons), .in_machines(in_machines),
        .lsu_start(lsu_start8), .lsu_available(lsu_available), .lsu_button_count(lsu_button_count8),
        .lsu_buttons(lsu_buttons8), .lsu_machines(lsu_machines8), .lsu_result_ready(lsu_result_ready),
        .lsu_results(lsu_results),
`ifdef DISPATCH_STATS_EN
        .lines_done(lines_done8), .max_result(max_result8),
`endif
        .total(total8), .done(done8), .unsolvable(unsolvable8)
    );

    // Start monitor: every nonzero lsu_start must match the next queued dispatch.
    always @(negedge clk) begin
        if (!reset && (lsu_start != 4'b0000 || lsu_start8 != 4'b0000)) begin
            start_cnt++;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL start_unexpected got=%b", lsu_start);
            end else begin
                mon_e = exp_q.pop_front();
                if (lsu_start !== mon_e.start || lsu_start8 !== mon_e.start
                    || lsu_button_count !== mon_e.ln.button_count || lsu_buttons !== mon_e.ln.buttons
                    || lsu_machines !== mon_e.ln.machines || lsu_buttons8 !== mon_e.ln.buttons
                    || lsu_button_count8 !== mon_e.ln.button_count || lsu_machines8 !== mon_e.ln.machines)
                    $display("FAIL start_dispatch got=%b/%b bc=%0d want=%b bc=%0d", lsu_start, lsu_start8,
                             lsu_button_count, mon_e.start, mon_e.ln.button_count);
                else
                    pass_cnt++;
            end
        end
    end

    // Total monitor: queued entries are compared the half cycle after the consuming edge.
    always @(negedge clk) begin
        if (exp_total_q.size() != 0) begin
            mon_t = exp_total_q.pop_front();
            chk_cnt++;
            if (total !== mon_t[31:0] || total8 !== mon_t[7:0] || unsolvable !== mon_t[32]
                || unsolvable8 !== mon_t[32])
                $display("FAIL total_update got=%0d/%0d uns=%b want=%0d uns=%b", total, total8,
                         unsolvable, mon_t[31:0], mon_t[32]);
            else
                pass_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        lsu_result_ready = '0;
        exp_q.delete();
        exp_total_q.delete();
        model_total = '0;
        model_unsolv = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic send_line(input logic last, input logic [3:0] exp_start, output int waits);
        exp_t e;
        last_line.button_count = BCW'($urandom_range(0, MBC));
        last_line.buttons = (MC*MBC)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        last_line.machines = (MC*BPJ)'({$urandom(), $urandom(), $urandom()});
        waits = 0;
        while (!in_ready && waits < 50) begin
            step();
            waits++;
        end
        if (!in_ready) begin
            chk_cnt++;
            $display("FAIL accept_timeout in_ready=%b want=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_last = last;
        in_button_count = last_line.button_count;
        in_buttons = last_line.buttons;
        in_machines = last_line.machines;
        if (exp_start != 4'b0000) begin
            e.start = exp_start;
            e.ln = last_line;
            exp_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        in_buttons = '0;
    endtask

    task automatic pulse(input logic [3:0] rdy, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] r3);
        logic [AW-1:0] r[4];
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                if (r[i] == 16'hFFFF) model_unsolv = 1'b1;
                else model_total = model_total + 32'(r[i]);
            end
        end
        lsu_result_ready = rdy;
        lsu_results = {r3, r2, r1, r0};
        step();
        exp_total_q.push_back({model_unsolv, model_total});
        lsu_result_ready = '0;
        lsu_results = {4{16'h5A5A}};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        chk_cnt++;
        if (in_ready !== 1'b0 || lsu_start !== 4'b0000) $display("FAIL reset_ctrl in_ready=%b start=%b want 0/0000", in_ready, lsu_start);
        else pass_cnt++;
        chk_cnt++;
        if (lsu_button_count !== '0 || lsu_buttons !== '0 || lsu_machines !== '0) $display("FAIL reset_bus bc=%0d want 0", lsu_button_count);
        else pass_cnt++;
        chk_cnt++;
        if (total !== 32'd0 || done !== 1'b0 || unsolvable !== 1'b0) $display("FAIL reset_status total=%0d done=%b uns=%b want 0", total, done, unsolvable);
        else pass_cnt++;
        reset = 1'b0;
        step();
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_example();
        int w;
        do_reset();
        lsu_available = 4'b1111;
        send_line(1'b0, 4'b0001, w);
        send_line(1'b0, 4'b0001, w);
        chk_cnt++;
        if (w !== 2) $display("FAIL back_to_back waits=%0d want 2", w);
        else pass_cnt++;
        send_line(1'b1, 4'b0001, w);
        step();
        pulse(4'b0001, 16'd10, 16'd0, 16'd0, 16'd0);
        pulse(4'b0010, 16'd0, 16'd12, 16'd0, 16'd0);
        step();
        chk_cnt++;
        if (done !== 1'b0 || in_ready !== 1'b0) $display("FAIL example_early done=%b in_ready=%b want 0/0", done, in_ready);
        else pass_cnt++;
        pulse(4'b0100, 16'd0, 16'd0, 16'd11, 16'd0);
        step();
        step();
        chk_cnt++;
        if (total !== 32'd33 || done !== 1'b1 || unsolvable !== 1'b0) $display("FAIL example_done total=%0d done=%b uns=%b want 33/1/0", total, done, unsolvable);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        int w;
        logic [3:0] avail[3] = '{4'b1010, 4'b1100, 4'b1000};
        logic [3:0] want[3]  = '{4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            lsu_available = avail[k];
            send_line(1'b0, want[k], w);
            step();
            step();
        end
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL priority_drain left=%0d want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_no_lsu();
        int w;
        int s0;
        exp_t e;
        do_reset();
        lsu_available = 4'b0000;
        s0 = start_cnt;
        send_line(1'b0, 4'b0000, w);
        repeat (20) step();
        chk_cnt++;
        if (start_cnt !== s0 || in_ready !== 1'b0) $display("FAIL held_idle starts=%0d in_ready=%b want 0/0", start_cnt - s0, in_ready);
        else pass_cnt++;
        e.start = 4'b0010;
        e.ln = last_line;
        exp_q.push_back(e);
        lsu_available = 4'b0110;
        step();
        step();
        step();
        chk_cnt++;
        if (start_cnt !== s0 + 1 || in_ready !== 1'b1) $display("FAIL held_release starts=%0d in_ready=%b want 1/1", start_cnt - s0, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_multi_result();
        int w;
        do_reset();
        lsu_available = 4'b1111;
        repeat (3) send_line(1'b0, 4'b0001, w);
        step();
        step();
        pulse(4'b1011, 16'd5, 16'd7, 16'h1234, 16'd9);
        step();
        chk_cnt++;
        if (total !== 32'd21) $display("FAIL multi_sum total=%0d want 21", total);
        else pass_cnt++;
`ifdef DISPATCH_STATS_EN
        chk_cnt++;
        if (lines_done !== 32'd3) $display("FAIL multi_lines_done got=%0d want 3", lines_done);
        else pass_cnt++;
`endif
        send_line(1'b1, 4'b0001, w);
        step();
        step();
        step();
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL multi_count_early done=%b want 0", done);
        else pass_cnt++;
        pulse(4'b0001, 16'd1, 16'd0, 16'd0, 16'd0);
        step();
        step();
        chk_cnt++;
        if (done !== 1'b1 || total !== 32'd22) $display("FAIL multi_done done=%b total=%0d want 1/22", done, total);
        else pass_cnt++;
    endtask

    task automatic test_unsolvable();
        int w;
        do_reset();
        lsu_available = 4'b1111;
        send_line(1'b0, 4'b0001, w);
        send_line(1'b1, 4'b0001, w);
        step();
        pulse(4'b0001, 16'd8, 16'd0, 16'd0, 16'd0);
        pulse(4'b0100, 16'd0, 16'd0, 16'hFFFF, 16'd0);
        repeat (4) step();
        chk_cnt++;
        if (unsolvable !== 1'b1 || done !== 1'b1 || total !== 32'd8) $display("FAIL unsolvable_sticky uns=%b done=%b total=%0d want 1/1/8", unsolvable, done, total);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int w;
        int s0;
        do_reset();
        lsu_available = 4'b1111;
        send_line(1'b0, 4'b0001, w);
        send_line(1'b0, 4'b0001, w);
        step();
        pulse(4'b0010, 16'd0, 16'd30, 16'd0, 16'd0);
        lsu_available = 4'b0000;
        send_line(1'b0, 4'b0000, w);
        step();
        s0 = start_cnt;
        reset = 1'b1;
        model_total = '0;
        model_unsolv = 1'b0;
        step();
        chk_cnt++;
        if (total !== 32'd0 || lsu_start !== 4'b0000 || done !== 1'b0) $display("FAIL midreset_state total=%0d start=%b done=%b want 0", total, lsu_start, done);
        else pass_cnt++;
        reset = 1'b0;
        lsu_available = 4'b1111;
        step();
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midreset_ready in_ready=%b want 1", in_ready);
        else pass_cnt++;
        repeat (3) step();
        chk_cnt++;
        if (start_cnt !== s0) $display("FAIL midreset_discard starts=%0d want 0", start_cnt - s0);
        else pass_cnt++;
    endtask

    task automatic test_wrap_stats();
        do_reset();
        pulse(4'b0011, 16'd200, 16'd54, 16'd0, 16'd0);
        chk_cnt++;
        if (total8 !== 8'hFE) $display("FAIL wrap_pre total8=%h want fe", total8);
        else pass_cnt++;
        pulse(4'b0001, 16'd5, 16'd0, 16'd0, 16'd0);
        chk_cnt++;
        if (total8 !== 8'h03 || total !== 32'd259) $display("FAIL wrap_post total8=%h total=%0d want 03/259", total8, total);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready8 !== 1'b1 || done8 !== 1'b0 || unsolvable8 !== 1'b0) $display("FAIL wrap_ctrl rdy=%b done=%b uns=%b want 1/0/0", in_ready8, done8, unsolvable8);
        else pass_cnt++;
`ifdef DISPATCH_STATS_EN
        do_reset();
        chk_cnt++;
        if (max_result !== 16'd0) $display("FAIL stats_reset max=%0d want 0", max_result);
        else pass_cnt++;
        pulse(4'b0001, 16'd3, 16'd0, 16'd0, 16'd0);
        pulse(4'b0010, 16'd0, 16'd40, 16'd0, 16'd0);
        pulse(4'b0100, 16'd0, 16'd0, 16'd17, 16'd0);
        pulse(4'b1000, 16'd0, 16'd0, 16'd0, 16'hFFFF);
        chk_cnt++;
        if (max_result !== 16'd40 || max_result8 !== 16'd40 || lines_done !== 32'd4 || lines_done8 !== 8'd4)
            $display("FAIL stats max=%0d lines=%0d want 40/4", max_result, lines_done);
        else pass_cnt++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout time=%0t want finish", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_example();
        test_priority();
        test_no_lsu();
        test_multi_result();
        test_unsolvable();
        test_reset_mid();
        test_wrap_stats();
        step();
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL start_queue_left got=%0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
